// File: rtl/updown_target_ctrl.sv
// updown_target_ctrl: steps an up/down counter toward a requested target (macro UPDOWN_SHORTEST_PATH_EN selects modular shortest-path direction)
module updown_target_ctrl #(
  parameter int W          = 2,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_STEPS  = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_target,
  input  logic [W-1:0] q_in,
  output logic         t,
  output logic         up,
  output logic         busy,
  output logic         done,
  output logic         err_timeout
);
  typedef enum logic [2:0] {IDLE, CHECK, PULSE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [7:0] step_q, step_d;
  logic [3:0] settle_q, settle_d;
  logic t_d, up_q, up_d, busy_d, done_d, err_q, err_d;
  logic dir;
`ifdef UPDOWN_SHORTEST_PATH_EN
  logic [W-1:0] d_up, d_dn;
  assign d_up = tgt_q - q_in;
  assign d_dn = q_in - tgt_q;
  assign dir  = d_up <= d_dn;
`else
  assign dir = tgt_q > q_in;
`endif
  assign req_ready   = (state_q == IDLE) && !rst;
  assign up          = up_q;
  assign err_timeout = err_q;
  // next state, latched request data and registered output values
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    settle_d = settle_q;
    up_d     = up_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        tgt_d   = req_target;
        step_d  = '0;
        state_d = CHECK;
      end
      CHECK: if (q_in == tgt_q) state_d = DONE;
        else if (step_q == 8'(MAX_STEPS)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          up_d    = dir;
          state_d = PULSE;
        end
      PULSE: begin
        step_d   = step_q + 8'd1;
        settle_d = 4'(SETTLE_CYC);
        state_d  = WAIT;
      end
      WAIT: begin
        settle_d = settle_q - 4'd1;
        state_d  = settle_q == 4'd1 ? CHECK : WAIT;
      end
      default: state_d = IDLE;
    endcase
    t_d    = state_d == PULSE;
    busy_d = state_d inside {CHECK, PULSE, WAIT};
    done_d = state_d == DONE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      step_q   <= '0;
      settle_q <= '0;
      t        <= 1'b0;
      up_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      t        <= t_d;
      up_q     <= up_d;
      busy     <= busy_d;
      done     <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_updown_target_ctrl.sv
// tb_updown_target_ctrl: scoreboard bench with a behavioural 2-bit up/down counter in the loop
module tb_updown_target_ctrl;
  localparam int W = 2, SC = 2, MS = 7, P = 2 + SC;
  logic clk = 0, rst = 1, req_valid = 0;
  logic [1:0] req_target = 0, q_in;
  logic req_ready, t, up, busy, done, err_timeout;
  logic ld = 0, frz = 0;
  logic [1:0] ld_v = 0, qm = 0;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int cyc; bit err; logic [1:0] fq; int np; bit upv;} item_t;
  item_t sb[$];
  bit active = 0;
  int st = 0, np = 0, nb = 0;
  item_t it;

  updown_target_ctrl #(.W(W), .SETTLE_CYC(SC), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .q_in(q_in), .t(t), .up(up), .busy(busy),
    .done(done), .err_timeout(err_timeout)
  );

  assign q_in = qm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (ld) qm <= ld_v;
    else if (t && !frz) qm <= up ? qm + 2'd1 : qm - 2'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) active = 0;
    else begin
      if (req_valid && req_ready) begin
        active = 1; st = cyc; np = 0; nb = 0;
      end else if (active) begin
        if (t) begin
          if (sb.size() > 0) begin
            chk("pulse_up", up, sb[0].upv);
            chk("pulse_cyc", cyc - st, 2 + np * P);
          end
          np++;
        end
        if (busy) nb++;
      end
      if (done) begin
        if (sb.size() == 0) chk("done_without_request", done, 0);
        else begin
          it = sb.pop_front();
          chk("done_cyc", cyc - st, it.cyc);
          chk("err_timeout", err_timeout, it.err);
          chk("final_q", qm, it.fq);
          chk("pulses", np, it.np);
          chk("busy_cyc", nb, it.cyc - 1);
        end
        active = 0;
      end
    end
  end

  task automatic req(input logic [1:0] tgt, input logic [1:0] q0, input bit fz, input bit push, input item_t e);
    int n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", req_ready, 1);
    ld = 1; ld_v = q0; frz = fz;
    @(posedge clk); #1 ld = 0;
    if (push) sb.push_back(e);
    req_target = tgt; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    item_t e2, e3;
    int n;
`ifdef UPDOWN_SHORTEST_PATH_EN
    e2 = item_t'{6, 0, 2'd3, 1, 0};
    e3 = item_t'{10, 0, 2'd1, 2, 1};
`else
    e2 = item_t'{14, 0, 2'd3, 3, 1};
    e3 = item_t'{10, 0, 2'd1, 2, 0};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_t", t, 0);
    chk("rst_up", up, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", req_ready, 0);
    rst = 0;
    #1 chk("ready_after_rst", req_ready, 1);
    req(2'd2, 2'd2, 0, 1, item_t'{2, 0, 2'd2, 0, 0});
    req(2'd3, 2'd0, 0, 1, e2);
    req(2'd1, 2'd3, 0, 1, e3);
    req(2'd2, 2'd0, 1, 1, item_t'{30, 1, 2'd0, 7, 1});
    req(2'd0, 2'd1, 0, 1, item_t'{6, 0, 2'd0, 1, 0});
    req(2'd2, 2'd0, 0, 0, e2);
    repeat (6) @(posedge clk);
    #1 chk("busy_before_rst", busy, 1);
    chk("up_before_rst", up, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_t", t, 0);
    chk("abort_busy", busy, 0);
    chk("abort_up", up, 0);
    chk("abort_done", done, 0);
    repeat (12) @(posedge clk);
    req(2'd3, 2'd0, 0, 1, e2);
    repeat (3) @(posedge clk);
    #1 req_valid = 1; req_target = 2'd1;
    chk("ready_while_busy", req_ready, 0);
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk); n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
